vm_receipt: RTL and testbench

Output-side receiver for the vending machine. It watches the VM result burst (out_valid, out_consumer, out_sell_num, out_monitor) and checks that the burst is well formed. It deserialises the burst into one parallel receipt with the computed change total, and presents that receipt on a valid/ready handshake to the host or scoreboard logic downstream. It also keeps a registered copy of the live balance display.

---
 rtl/vm_pkg.sv | 24 ++
 rtl/vm_change_calc.sv | 23 ++
 rtl/vm_receipt.sv | 152 +++++++++++++++
 tb/tb_vm_receipt.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared constants, widths and FSM state type for the vending-machine receipt path.
package vm_pkg;
   localparam int unsigned COIN_50 = 50;
   localparam int unsigned COIN_20 = 20;
   localparam int unsigned COIN_10 = 10;
   localparam int unsigned COIN_5  = 5;
   localparam int unsigned COIN_1  = 1;

   localparam int unsigned BURST_LEN = 6;
   localparam int unsigned N_ITEM    = 6;
   localparam int unsigned N_COIN    = 5;

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned SELL_W = 6;
   localparam int unsigned BAL_W  = 9;
   localparam int unsigned CHG_W  = 11;
   localparam int unsigned ITEM_W = 3;
   localparam int unsigned BEAT_W = 3;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]  MAX_ITEM  = CNT_W'(N_ITEM);

   typedef enum logic [1:0] {IDLE, CAP, CHK, DRAIN} state_e;
endpackage

// File: rtl/vm_change_calc.sv
// Combinational weighted sum of the five change-coin counts, built from shifts and adds.
module vm_change_calc
   import vm_pkg::*;
(
   input  logic [N_COIN*CNT_W-1:0] coins,
   output logic [CHG_W-1:0]        change
);
   logic [CHG_W-1:0] c50, c20, c10, c5, c1;

   always_comb begin
      c50 = CHG_W'(coins[0*CNT_W +: CNT_W]);
      c20 = CHG_W'(coins[1*CNT_W +: CNT_W]);
      c10 = CHG_W'(coins[2*CNT_W +: CNT_W]);
      c5  = CHG_W'(coins[3*CNT_W +: CNT_W]);
      c1  = CHG_W'(coins[4*CNT_W +: CNT_W]);
      // 50 = 32+16+2, 20 = 16+4, 10 = 8+2, 5 = 4+1
      change = (c50 << 5) + (c50 << 4) + (c50 << 1)
             + (c20 << 4) + (c20 << 2)
             + (c10 << 3) + (c10 << 1)
             + (c5 << 2) + c5
             + c1;
   end
endmodule

// File: rtl/vm_receipt.sv
// Checks and deserialises the 6-beat VM result burst into one receipt presented on valid/ready,
// and keeps a registered copy of the balance display.
module vm_receipt
   import vm_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [CNT_W-1:0]          in_consumer,
   input  logic [SELL_W-1:0]         in_sell_num,
   input  logic [BAL_W-1:0]          in_monitor,
   input  logic                      rcpt_ready,
   output logic                      rcpt_valid,
   output logic [ITEM_W-1:0]         rcpt_item,
   output logic [N_COIN*CNT_W-1:0]   rcpt_coins,
   output logic [CHG_W-1:0]          rcpt_change,
   output logic [N_ITEM*SELL_W-1:0]  rcpt_sell,
   output logic                      rcpt_lost,
   output logic [BAL_W-1:0]          bal,
   output logic                      err
);
   state_e                     state_q, state_d;
   logic [BEAT_W-1:0]          cnt_q, cnt_d;
   logic [CNT_W-1:0]           item_q, item_d;
   logic [N_COIN*CNT_W-1:0]    coins_q, coins_d;
   logic [N_ITEM*SELL_W-1:0]   sell_q, sell_d;
   logic [CHG_W-1:0]           change_w;
   logic                       commit;

   logic                       rcpt_valid_q, rcpt_valid_d;
   logic [ITEM_W-1:0]          rcpt_item_q, rcpt_item_d;
   logic [N_COIN*CNT_W-1:0]    rcpt_coins_q, rcpt_coins_d;
   logic [CHG_W-1:0]           rcpt_change_q, rcpt_change_d;
   logic [N_ITEM*SELL_W-1:0]   rcpt_sell_q, rcpt_sell_d;
   logic                       rcpt_lost_q, rcpt_lost_d;
   logic [BAL_W-1:0]           bal_q, bal_d;
   logic                       err_q, err_d;

   vm_change_calc u_change (
      .coins  (coins_q),
      .change (change_w)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      item_d  = item_q;
      coins_d = coins_q;
      sell_d  = sell_q;
      commit  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               item_d              = in_consumer;
               sell_d[SELL_W-1:0]  = in_sell_num;
               cnt_d               = BEAT_W'(1);
               state_d             = CAP;
            end
         end
         CAP: begin
            if (in_valid) begin
               for (int unsigned k = 1; k < BURST_LEN; k++) begin
                  if (cnt_q == BEAT_W'(k)) begin
                     coins_d[(k-1)*CNT_W +: CNT_W] = in_consumer;
                     sell_d[k*SELL_W +: SELL_W]    = in_sell_num;
                  end
               end
               cnt_d = cnt_q + BEAT_W'(1);
               if (cnt_q == LAST_BEAT) state_d = CHK;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         CHK: begin
            if (in_valid) begin
               err_d   = 1'b1;
               state_d = DRAIN;
            end else begin
               commit  = 1'b1;
               err_d   = (item_q > MAX_ITEM);
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (!in_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rcpt_valid_d  = rcpt_valid_q & ~rcpt_ready;
      rcpt_item_d   = rcpt_item_q;
      rcpt_coins_d  = rcpt_coins_q;
      rcpt_change_d = rcpt_change_q;
      rcpt_sell_d   = rcpt_sell_q;
      rcpt_lost_d   = rcpt_lost_q;
      if (commit) begin
         rcpt_valid_d  = 1'b1;
         rcpt_item_d   = (item_q > MAX_ITEM) ? '0 : item_q[ITEM_W-1:0];
         rcpt_coins_d  = coins_q;
         rcpt_change_d = change_w;
         rcpt_sell_d   = sell_q;
         // Only a receipt that was not taken in this same cycle counts as lost
         rcpt_lost_d   = rcpt_valid_q & ~rcpt_ready;
      end
      bal_d = in_valid ? bal_q : in_monitor;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         item_q        <= '0;
         coins_q       <= '0;
         sell_q        <= '0;
         rcpt_valid_q  <= 1'b0;
         rcpt_item_q   <= '0;
         rcpt_coins_q  <= '0;
         rcpt_change_q <= '0;
         rcpt_sell_q   <= '0;
         rcpt_lost_q   <= 1'b0;
         bal_q         <= '0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         item_q        <= item_d;
         coins_q       <= coins_d;
         sell_q        <= sell_d;
         rcpt_valid_q  <= rcpt_valid_d;
         rcpt_item_q   <= rcpt_item_d;
         rcpt_coins_q  <= rcpt_coins_d;
         rcpt_change_q <= rcpt_change_d;
         rcpt_sell_q   <= rcpt_sell_d;
         rcpt_lost_q   <= rcpt_lost_d;
         bal_q         <= bal_d;
         err_q         <= err_d;
      end
   end

   assign rcpt_valid  = rcpt_valid_q;
   assign rcpt_item   = rcpt_item_q;
   assign rcpt_coins  = rcpt_coins_q;
   assign rcpt_change = rcpt_change_q;
   assign rcpt_sell   = rcpt_sell_q;
   assign rcpt_lost   = rcpt_lost_q;
   assign bal         = bal_q;
   assign err         = err_q;
endmodule

// File: tb/tb_vm_receipt.sv
// Randomised scoreboard bench for vm_receipt: stimulus pushes expected receipts, a negedge monitor checks them.
module tb_vm_receipt;
   import vm_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [3:0]   in_consumer = '0;
   logic [5:0]   in_sell_num = '0;
   logic [8:0]   in_monitor = '0;
   logic         rcpt_ready = 1'b0;
   logic         rcpt_valid;
   logic [2:0]   rcpt_item;
   logic [19:0]  rcpt_coins;
   logic [10:0]  rcpt_change;
   logic [35:0]  rcpt_sell;
   logic         rcpt_lost;
   logic [8:0]   bal;
   logic         err;

   vm_receipt dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_consumer (in_consumer),
      .in_sell_num (in_sell_num),
      .in_monitor  (in_monitor),
      .rcpt_ready  (rcpt_ready),
      .rcpt_valid  (rcpt_valid),
      .rcpt_item   (rcpt_item),
      .rcpt_coins  (rcpt_coins),
      .rcpt_change (rcpt_change),
      .rcpt_sell   (rcpt_sell),
      .rcpt_lost   (rcpt_lost),
      .bal         (bal),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  item;
      logic [19:0] coins;
      logic [10:0] change;
      logic [35:0] sell;
      logic        lost;
   } rcpt_t;

   int     tests = 0;
   int     fails = 0;
   rcpt_t  sb[$];
   rcpt_t  nxt;
   logic   nxt_bad = 1'b0;
   logic   pend = 1'b0;
   logic   err_exp = 1'b0;
   logic [8:0] bal_exp = '0;
   logic   chk_en = 1'b0;
   logic   ready_force = 1'b1;
   logic   ready_val = 1'b0;
   logic   rand_mon = 1'b1;
   logic [3:0] b_item;
   logic [3:0] b_coin[5];
   logic [5:0] b_sell[6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected receipt straight from the burst contents
   task automatic prep();
      int unsigned sum;
      sum = COIN_50 * b_coin[0] + COIN_20 * b_coin[1] + COIN_10 * b_coin[2]
          + COIN_5 * b_coin[3] + COIN_1 * b_coin[4];
      nxt_bad    = (b_item >= 4'd7);
      nxt.item   = nxt_bad ? 3'd0 : b_item[2:0];
      nxt.change = 11'(sum);
      for (int i = 0; i < 5; i++) nxt.coins[i*4 +: 4] = b_coin[i];
      for (int i = 0; i < 6; i++) nxt.sell[i*6 +: 6] = b_sell[i];
      nxt.lost = 1'b0;
   endtask

   // ev: 0 = nothing, 1 = this edge commits a receipt, 2 = this edge detects a malformed burst
   task automatic step(input int ev);
      @(posedge clk);
      if (!in_valid) bal_exp = in_monitor;
      err_exp = (ev == 2) || (ev == 1 && nxt_bad);
      if (ev == 1) begin
         if (pend && !rcpt_ready) begin
            if (sb.size() > 0) void'(sb.pop_back());
            nxt.lost = 1'b1;
         end else begin
            nxt.lost = 1'b0;
         end
         sb.push_back(nxt);
         pend = 1'b1;
      end else if (pend && rcpt_ready) begin
         pend = 1'b0;
      end
      #1;
      rcpt_ready = ready_force ? ready_val : ($urandom_range(0, 2) != 0);
      if (rand_mon) in_monitor = 9'($urandom);
   endtask

   task automatic set_ready(input logic v);
      ready_force = 1'b1;
      ready_val   = v;
      rcpt_ready  = v;
   endtask

   task automatic set_burst(input logic [3:0] it, input logic [3:0] c0, c1, c2, c3, c4,
                            input logic [5:0] s0, s1, s2, s3, s4, s5);
      b_item = it;
      b_coin[0] = c0; b_coin[1] = c1; b_coin[2] = c2; b_coin[3] = c3; b_coin[4] = c4;
      b_sell[0] = s0; b_sell[1] = s1; b_sell[2] = s2; b_sell[3] = s3; b_sell[4] = s4; b_sell[5] = s5;
   endtask

   task automatic rand_burst();
      b_item = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      for (int i = 0; i < 5; i++) b_coin[i] = 4'($urandom);
      for (int i = 0; i < 6; i++) b_sell[i] = 6'($urandom);
   endtask

   task automatic send_burst(input int len, input int gap);
      prep();
      for (int b = 0; b < len; b++) begin
         in_valid = 1'b1;
         if (b == 0)      in_consumer = b_item;
         else if (b <= 5) in_consumer = b_coin[b-1];
         else             in_consumer = 4'($urandom);
         if (b <= 5) in_sell_num = b_sell[b];
         else        in_sell_num = 6'($urandom);
         step((b == 6) ? 2 : 0);
      end
      in_valid    = 1'b0;
      in_consumer = 4'($urandom);
      in_sell_num = 6'($urandom);
      step((len == 6) ? 1 : ((len >= 1 && len <= 5) ? 2 : 0));
      for (int g = 1; g < gap; g++) step(0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("rcpt_valid", 64'(rcpt_valid), 64'(pend));
         chk("err", 64'(err), 64'(err_exp));
         chk("bal", 64'(bal), 64'(bal_exp));
         if (rcpt_valid) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rcpt_unexpected: got rcpt_valid=1, expected no receipt (t=%0t)", $time);
            end else begin
               chk("rcpt_item", 64'(rcpt_item), 64'(sb[0].item));
               chk("rcpt_coins", 64'(rcpt_coins), 64'(sb[0].coins));
               chk("rcpt_change", 64'(rcpt_change), 64'(sb[0].change));
               chk("rcpt_sell", 64'(rcpt_sell), 64'(sb[0].sell));
               chk("rcpt_lost", 64'(rcpt_lost), 64'(sb[0].lost));
               if (rcpt_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no end of test, expected $finish before 1ms");
      $fatal(1);
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(rcpt_valid), 64'd0);
      chk({tag, "_item"}, 64'(rcpt_item), 64'd0);
      chk({tag, "_coins"}, 64'(rcpt_coins), 64'd0);
      chk({tag, "_change"}, 64'(rcpt_change), 64'd0);
      chk({tag, "_sell"}, 64'(rcpt_sell), 64'd0);
      chk({tag, "_lost"}, 64'(rcpt_lost), 64'd0);
      chk({tag, "_bal"}, 64'(bal), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      in_monitor = 9'd5;
      @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Well-formed burst with ready held high
      set_ready(1'b1);
      set_burst(4'd3, 4'd1, 4'd2, 4'd0, 4'd1, 4'd3, 6'd0, 6'd0, 6'd1, 6'd0, 6'd0, 6'd0);
      send_burst(6, 3);
      chk("d1_accepted", 64'(rcpt_valid), 64'd0);

      // Return burst held by downstream for 5 cycles
      set_ready(1'b0);
      set_burst(4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9);
      send_burst(6, 1);
      repeat (5) step(0);
      chk("d2_held_valid", 64'(rcpt_valid), 64'd1);
      chk("d2_change", 64'(rcpt_change), 64'd17);
      set_ready(1'b1);
      step(0);
      chk("d2_dropped", 64'(rcpt_valid), 64'd0);

      // Short burst, then long burst followed by a good burst
      rand_burst();
      send_burst(4, 2);
      rand_burst();
      send_burst(8, 1);
      set_burst(4'd6, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 6'd63, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
      send_burst(6, 2);

      // Overwrite of an unaccepted receipt
      set_ready(1'b0);
      set_burst(4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
      send_burst(6, 1);
      set_burst(4'd2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd4, 6'd0, 6'd1, 6'd0, 6'd0, 6'd0, 6'd0);
      send_burst(6, 1);
      chk("d5_lost", 64'(rcpt_lost), 64'd1);
      chk("d5_change", 64'(rcpt_change), 64'd24);
      set_ready(1'b1);
      step(0);
      step(0);

      // Reset in the middle of a burst
      rand_mon   = 1'b0;
      in_monitor = 9'd137;
      step(0);
      step(0);
      chk("r_bal_before", 64'(bal), 64'd137);
      rand_burst();
      for (int b = 0; b < 3; b++) begin
         in_valid    = 1'b1;
         in_consumer = (b == 0) ? b_item : b_coin[0];
         in_sell_num = b_sell[0];
         step(0);
      end
      in_valid = 1'b1;
      #1;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      in_monitor = 9'd42;
      pend       = 1'b0;
      sb.delete();
      err_exp    = 1'b0;
      bal_exp    = '0;
      rst_n      = 1'b1;
      chk_en     = 1'b1;
      step(0);
      chk("r_bal_after", 64'(bal), 64'd42);
      rand_mon = 1'b1;

      // Randomised traffic
      ready_force = 1'b0;
      for (int n = 0; n < 200; n++) begin
         int r;
         int len;
         r = int'($urandom_range(0, 9));
         if (r < 7)       len = 6;
         else if (r == 7) len = int'($urandom_range(1, 5));
         else             len = int'($urandom_range(7, 9));
         rand_burst();
         send_burst(len, int'($urandom_range(1, 3)));
      end

      set_ready(1'b1);
      repeat (4) step(0);
      chk("drain_empty", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
